spi_sram_target: RTL and testbench
==================================

// Module: spi_sram_target
// PURPOSE
// - SPI mode-0 target (responder) for the 23LC-style serial SRAM command set issued by the SoC's spi_sram initiator.
// - Holds 2**ADDR_W bytes of internal byte storage; drives MISO back to the initiator.
// - Used as the on-die / FPGA stand-in for the external SPI SRAM and as the bench responder for SoC-level tests.
// - All SPI pins are oversampled by i_clk; there is no SCLK clock domain.
// PARAMETERS
// - ADDR_W   9    storage address bits; depth = 2**ADDR_W bytes; SPI address bits [15:ADDR_W] ignored
// - SYNC_STG 2    synchronizer flops on i_spi_clk, i_spi_cs_n, i_spi_mosi (>=2)
// PORTS
// - i_clk          in   1  system clock; SCLK must be <= i_clk/4
// - i_rst          in   1  synchronous, active-high reset
// - i_spi_cs_n     in   1  chip select, active low
// - i_spi_clk      in   1  SPI clock, mode 0 (idle low)
// - i_spi_mosi     in   1  serial data from initiator, MSB first
// - o_spi_miso     out  1  serial data to initiator, MSB first
// - o_spi_miso_oe  out  1  1 while CS asserted and in a read-data phase
// - o_busy         out  1  1 while CS (synchronized) is asserted
// BEHAVIOUR
// - Reset: o_spi_miso=0, o_spi_miso_oe=0, o_busy=0, FSM=IDLE, bit count=0; storage contents not reset.
// - Edge detect on synchronized SCLK: rise = sample MOSI, fall = shift MISO. Latency pin->action = SYNC_STG+1 i_clk.
// - FSM: IDLE -(CS fall)-> CMD -(8 rises)-> ADDR | MODE_RD | MODE_WR | IGNORE.
// - CMD 0x03 READ, 0x02 WRITE -> ADDR; other opcodes -> IGNORE (MISO=0, oe=0, until CS rise).
// - ADDR: 16 bits MSB first; after 16th rise -> RDATA (READ) or WDATA (WRITE).
// - RDATA: byte at addr loaded into shift reg on 16th addr rise; bit7 on MISO before next SCLK rise
//   (driven within SYNC_STG+2 i_clk of that falling edge). Each falling edge shifts; after 8 bits addr+1, next byte loaded.
// - WDATA: 8 rises assemble a byte; written to storage[addr] in the i_clk cycle after the 8th rise; addr+1.
// - Address wrap: addr+1 at 2**ADDR_W-1 wraps to 0 (sequential mode, no page boundary).
// - CS rise (synchronized) in any state: -> IDLE next cycle, oe=0, MISO=0, bit count cleared; partial write byte discarded,
//   completed bytes kept. CS rise coincident with 8th write rise: byte IS written.
// - CS fall while already not IDLE cannot occur (CS rise always seen first); SCLK edges while CS high ignored.
// - i_rst mid-transaction: returns to reset state; pending partial byte dropped; in-flight completed write may not commit.
// - Simultaneous SCLK rise and fall in one i_clk cycle is illegal (guaranteed by SCLK <= i_clk/4).
// CONFIGURATION
// - SPI_SRAM_TGT_MODE_REG_EN defined: adds 8-bit mode register (reset 0x40 = sequential).
//   0x05 RDMR -> MODE_RD: shifts out mode reg, repeats every 8 bits until CS rise.
//   0x01 WRMR -> MODE_WR: next full byte written to mode reg; further bytes ignored. Mode value does not alter addressing.
// - Not defined: 0x05 and 0x01 decode as unknown opcodes -> IGNORE; no mode register flops.
// TESTING
// - Write then read: WRITE 0x02, addr 0x0010, data 0xA5 0x3C; READ 0x03 addr 0x0010, 16 clocks -> MISO 0xA5, 0x3C.
// - Wrap: ADDR_W=9, WRITE at 0x01FF data 0x11 0x22; READ 0x0000 -> 0x22; READ 0x01FF -> 0x11.
// - High addr bits ignored: WRITE 0xFE05 data 0x77; READ 0x0005 -> 0x77.
// - Abort: WRITE 0x0020 data 0x99 then 4 bits 1010, CS rise; READ 0x0020/0x0021 -> 0x99, prior 0x0021 value unchanged.
// - Unknown opcode 0x9F + 24 clocks -> oe=0, MISO=0 throughout; following READ works normally.
// - With SPI_SRAM_TGT_MODE_REG_EN: RDMR after reset -> 0x40; WRMR 0x00 then RDMR -> 0x00; without macro RDMR -> oe=0.

Source files
------------

// File: rtl/spi_sram_target.sv
// rtl/spi_sram_target.sv - SPI mode-0 serial SRAM target, oversampled by i_clk
// Optional RDMR/WRMR mode register enabled by SPI_SRAM_TGT_MODE_REG_EN.
module spi_sram_target #(
    parameter int ADDR_W   = 9,
    parameter int SYNC_STG = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_spi_cs_n,
    input  logic i_spi_clk,
    input  logic i_spi_mosi,
    output logic o_spi_miso,
    output logic o_spi_miso_oe,
    output logic o_busy
);
    localparam int DEPTH = 1 << ADDR_W;
    // Shift history only needs to cover the widest field minus the bit arriving now.
    localparam int RX_W  = (ADDR_W - 1 > 7) ? ADDR_W - 1 : 7;

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, RDATA, WDATA, MODE_RD, MODE_WR, IGNORE
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STG-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                sclk_prev;
    logic                sclk_s, cs_s, mosi_s, rise, fall;

    logic [3:0]          bit_cnt;
    logic [RX_W-1:0]     rx_sh;
    logic [7:0]          tx_sh;
    logic [ADDR_W-1:0]   addr;
    logic                is_read;
    logic                wr_pend;
    logic [7:0]          wr_data;
    logic                miso;
    logic [7:0]          rx_byte;
    logic [ADDR_W-1:0]   rx_addr, addr_inc;
    logic [7:0]          mem [DEPTH];
`ifdef SPI_SRAM_TGT_MODE_REG_EN
    logic [7:0]          mode_reg;
`endif

    assign sclk_s   = sclk_sync[SYNC_STG-1];
    assign cs_s     = cs_sync[SYNC_STG-1];
    assign mosi_s   = mosi_sync[SYNC_STG-1];
    assign rise     = sclk_s & ~sclk_prev;
    assign fall     = ~sclk_s & sclk_prev;
    assign rx_byte  = {rx_sh[6:0], mosi_s};
    assign rx_addr  = {rx_sh[ADDR_W-2:0], mosi_s};
    assign addr_inc = addr + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STG-2:0], i_spi_clk};
            cs_sync   <= {cs_sync[SYNC_STG-2:0], i_spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STG-2:0], i_spi_mosi};
            sclk_prev <= sclk_s;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!cs_s) state_nxt = CMD;
            CMD: begin
                if (rise && bit_cnt == 4'd7) begin
                    case (rx_byte)
                        8'h03, 8'h02: state_nxt = ADDR;
`ifdef SPI_SRAM_TGT_MODE_REG_EN
                        8'h05:        state_nxt = MODE_RD;
                        8'h01:        state_nxt = MODE_WR;
`endif
                        default:      state_nxt = IGNORE;
                    endcase
                end
            end
            ADDR: if (rise && bit_cnt == 4'd15) state_nxt = is_read ? RDATA : WDATA;
            MODE_WR: if (rise && bit_cnt == 4'd7) state_nxt = IGNORE;
            default: ;
        endcase
        if (cs_s) state_nxt = IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bit_cnt  <= '0;
            rx_sh    <= '0;
            tx_sh    <= '0;
            addr     <= '0;
            is_read  <= 1'b0;
            wr_pend  <= 1'b0;
            wr_data  <= '0;
            miso     <= 1'b0;
`ifdef SPI_SRAM_TGT_MODE_REG_EN
            mode_reg <= 8'h40;
`endif
        end else begin
            wr_pend <= 1'b0;
            if (wr_pend) addr <= addr_inc;
            if (rise) rx_sh <= {rx_sh[RX_W-2:0], mosi_s};
            case (state)
                CMD: if (rise) begin
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        bit_cnt <= '0;
                        is_read <= (rx_byte == 8'h03);
`ifdef SPI_SRAM_TGT_MODE_REG_EN
                        tx_sh   <= mode_reg;
`endif
                    end
                end
                ADDR: if (rise) begin
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd15) begin
                        bit_cnt <= '0;
                        addr    <= rx_addr;
                        tx_sh   <= mem[rx_addr];
                    end
                end
                RDATA: if (fall) begin
                    miso    <= tx_sh[7];
                    tx_sh   <= {tx_sh[6:0], 1'b0};
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        bit_cnt <= '0;
                        addr    <= addr_inc;
                        tx_sh   <= mem[addr_inc];
                    end
                end
                // Commit lands one cycle later so a coincident CS rise still keeps the byte.
                WDATA: if (rise) begin
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        bit_cnt <= '0;
                        wr_pend <= 1'b1;
                        wr_data <= rx_byte;
                    end
                end
`ifdef SPI_SRAM_TGT_MODE_REG_EN
                MODE_RD: if (fall) begin
                    miso    <= tx_sh[7];
                    tx_sh   <= {tx_sh[6:0], 1'b0};
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        bit_cnt <= '0;
                        tx_sh   <= mode_reg;
                    end
                end
                MODE_WR: if (rise) begin
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        bit_cnt  <= '0;
                        mode_reg <= rx_byte;
                    end
                end
`endif
                default: ;
            endcase
            if (cs_s) begin
                bit_cnt <= '0;
                miso    <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_pend) mem[addr] <= wr_data;
    end

    assign o_spi_miso    = miso;
    assign o_spi_miso_oe = ~cs_s & ((state == RDATA) | (state == MODE_RD));
    assign o_busy        = ~cs_s;

endmodule

// File: tb/tb_spi_sram_target.sv
// tb/tb_spi_sram_target.sv - scoreboard bench for spi_sram_target
// Mode register checks follow SPI_SRAM_TGT_MODE_REG_EN.
module tb_spi_sram_target;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cs_n = 1'b1;
    logic sclk = 1'b0;
    logic mosi = 1'b0;
    logic miso, miso_oe, busy;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_sh = '0;
    int mon_n = 0;
    logic quiet = 1'b0;

    always #5 clk = ~clk;

    spi_sram_target #(.ADDR_W(9), .SYNC_STG(2)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_spi_cs_n(cs_n),
        .i_spi_clk(sclk),
        .i_spi_mosi(mosi),
        .o_spi_miso(miso),
        .o_spi_miso_oe(miso_oe),
        .o_busy(busy)
    );

    // Monitor: the initiator samples MISO on SCLK rise; every full byte is scored.
    always @(posedge sclk) begin
        logic [7:0] e;
        if (miso_oe) begin
            mon_sh = {mon_sh[6:0], miso};
            mon_n++;
            if (mon_n == 8) begin
                mon_n = 0;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_byte: got %02h, required none", mon_sh);
                end else begin
                    e = exp_q.pop_front();
                    if (mon_sh !== e) begin
                        fails++;
                        $display("FAIL read_byte: got %02h, required %02h", mon_sh, e);
                    end
                end
            end
        end
        if (quiet) begin
            tests++;
            if (miso_oe !== 1'b0 || miso !== 1'b0) begin
                fails++;
                $display("FAIL quiet: oe=%0b miso=%0b, required 0 0", miso_oe, miso);
            end
        end
    end

    always @(posedge cs_n) mon_n = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %02h, required %02h", name, act, exp);
        end
    endtask

    task automatic cs_start();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            mosi = v[7-i];
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic head(input logic [7:0] op, input logic [15:0] a);
        spi_bits(op, 8);
        spi_bits(a[15:8], 8);
        spi_bits(a[7:0], 8);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d0, input logic [7:0] d1, input int n);
        cs_start();
        head(8'h02, a);
        spi_bits(d0, 8);
        if (n > 1) spi_bits(d1, 8);
        cs_end();
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] e0, input logic [7:0] e1, input int n);
        exp_q.push_back(e0);
        if (n > 1) exp_q.push_back(e1);
        cs_start();
        head(8'h03, a);
        for (int i = 0; i < n; i++) spi_bits(8'h00, 8);
        cs_end();
    endtask

    initial begin
        repeat (5) @(negedge clk);
        check("reset_miso", {7'd0, miso}, 8'h00);
        check("reset_oe", {7'd0, miso_oe}, 8'h00);
        check("reset_busy", {7'd0, busy}, 8'h00);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Write then read, with busy observed inside the transaction
        cs_start();
        check("busy_active", {7'd0, busy}, 8'h01);
        head(8'h02, 16'h0010);
        spi_bits(8'hA5, 8);
        spi_bits(8'h3C, 8);
        cs_end();
        check("busy_idle", {7'd0, busy}, 8'h00);
        rd(16'h0010, 8'hA5, 8'h3C, 2);

        // Address wrap at the top of storage
        wr(16'h01FF, 8'h11, 8'h22, 2);
        rd(16'h0000, 8'h22, 8'h00, 1);
        rd(16'h01FF, 8'h11, 8'h00, 1);
        rd(16'h01FF, 8'h11, 8'h22, 2);

        // High address bits ignored
        wr(16'hFE05, 8'h77, 8'h00, 1);
        rd(16'h0005, 8'h77, 8'h00, 1);

        // Abort mid-byte keeps completed bytes and discards the partial one
        wr(16'h0021, 8'h5A, 8'h00, 1);
        cs_start();
        head(8'h02, 16'h0020);
        spi_bits(8'h99, 8);
        spi_bits(8'hA0, 4);
        cs_end();
        rd(16'h0020, 8'h99, 8'h5A, 2);

        // Unknown opcode stays silent, next read is normal
        quiet = 1'b1;
        cs_start();
        spi_bits(8'h9F, 8);
        for (int i = 0; i < 3; i++) spi_bits(8'hFF, 8);
        cs_end();
        quiet = 1'b0;
        rd(16'h0010, 8'hA5, 8'h3C, 2);

`ifdef SPI_SRAM_TGT_MODE_REG_EN
        exp_q.push_back(8'h40);
        exp_q.push_back(8'h40);
        cs_start();
        spi_bits(8'h05, 8);
        spi_bits(8'h00, 8);
        spi_bits(8'h00, 8);
        cs_end();
        cs_start();
        spi_bits(8'h01, 8);
        spi_bits(8'h00, 8);
        spi_bits(8'hFF, 8);
        cs_end();
        exp_q.push_back(8'h00);
        cs_start();
        spi_bits(8'h05, 8);
        spi_bits(8'h00, 8);
        cs_end();
        rd(16'h0005, 8'h77, 8'h00, 1);
`else
        quiet = 1'b1;
        cs_start();
        spi_bits(8'h05, 8);
        spi_bits(8'h00, 8);
        spi_bits(8'h00, 8);
        cs_end();
        quiet = 1'b0;
        rd(16'h0005, 8'h77, 8'h00, 1);
`endif

        repeat (10) @(negedge clk);
        check("pending_expected", 8'(exp_q.size()), 8'h00);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
